// File: rtl/tx_cpl_ring_to_bram.sv
// Walks host huge pages round-robin, issues chunk reads and writes CplD payload into the TX ring BRAM.
// Latency: 1 cycle from a TRN payload beat to wr_en; wr_addr_updated is stretched for the slower reader clock.
// Backpressure: requests are held until read_chunk_ack; a beat arriving on a full ring is dropped. Option: TX_CPL_ERR_CNT_EN.
module tx_cpl_ring_to_bram #(
    parameter int ADDR_W       = 10,
    parameter int NUM_PAGES    = 2,
    parameter int CHUNK_QW     = 64,
    parameter int PULSE_CYCLES = 3
) (
    input  logic                    trn_clk,
    input  logic                    reset_n,
    input  logic [63:0]             trn_rd,
    input  logic                    trn_rsof_n,
    input  logic                    trn_reof_n,
    input  logic                    trn_rsrc_rdy_n,
    input  logic                    trn_rdst_rdy_n,
    input  logic [64*NUM_PAGES-1:0] huge_page_addr,
    input  logic [32*NUM_PAGES-1:0] huge_page_qwords,
    input  logic [NUM_PAGES-1:0]    huge_page_status,
    output logic [NUM_PAGES-1:0]    huge_page_free,
    output logic                    read_chunk,
    output logic [63:0]             read_chunk_addr,
    output logic [9:0]              read_chunk_qwords,
    input  logic                    read_chunk_ack,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [63:0]             wr_data,
    output logic                    wr_en,
    input  logic [ADDR_W-1:0]       commited_rd_address,
    input  logic                    commited_rd_address_change,
    output logic                    wr_addr_updated
`ifdef TX_CPL_ERR_CNT_EN
    ,
    output logic [15:0]             cpl_err_cnt
`endif
);
    localparam int IDX_W = (NUM_PAGES > 2) ? 2 : 1;
    localparam int UPD_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_ADV} req_state_t;
    typedef enum logic [1:0] {C_HDR, C_H2, C_DATA} cpl_state_t;

    req_state_t        req_state, req_next;
    cpl_state_t        cpl_state, cpl_next;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       offset, page_len, rem, new_off;
    logic [63:0]       page_base;
    logic [9:0]        req_qw, rcv_cnt, chunk_qw;
    logic              page_rdy, page_done, free_ok, err_hold;
    logic              chg_s1, chg_s2;
    logic [ADDR_W-1:0] rd_addr_q, rd_ptr, free_q, wr_next_addr;
    logic              beat, sof, eof, hdr_cpld, hdr_sc, data_beat, ring_full;
    logic [UPD_W-1:0]  upd_cnt;

    assign page_base = huge_page_addr[64*idx +: 64];
    assign page_len  = huge_page_qwords[32*idx +: 32];
    assign page_rdy  = huge_page_status[idx];
    assign rem       = (offset >= page_len) ? 32'd0 : page_len - offset;
    assign chunk_qw  = (rem > 32'(CHUNK_QW)) ? 10'(CHUNK_QW) : rem[9:0];
    assign new_off   = offset + 32'(req_qw);
    assign page_done = (new_off >= page_len);
    assign free_ok   = (free_q >= ADDR_W'(CHUNK_QW));

    assign beat     = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
    assign sof      = !trn_rsof_n;
    assign eof      = !trn_reof_n;
    assign hdr_cpld = (trn_rd[62:56] == 7'b10_01010);
    assign hdr_sc   = (trn_rd[15:13] == 3'b000);

    // Account for a write already in flight so the last free slot is never overwritten.
    assign wr_next_addr = wr_addr + ADDR_W'(wr_en);
    assign ring_full    = ((wr_next_addr + ONE) == rd_ptr);
    assign wr_addr_updated = (upd_cnt != '0);

`ifdef TX_CPL_ERR_CNT_EN
    logic hdr_reject;
    assign hdr_reject = (cpl_state == C_HDR) && beat && sof && hdr_cpld && !hdr_sc;
    assign err_hold   = (cpl_err_cnt != 16'd0);

    always_ff @(posedge trn_clk) begin
        if (!reset_n)
            cpl_err_cnt <= '0;
        else if (hdr_reject && cpl_err_cnt != 16'hFFFF)
            cpl_err_cnt <= cpl_err_cnt + 16'd1;
    end
`else
    assign err_hold = 1'b0;
`endif

    always_ff @(posedge trn_clk) begin
        if (!reset_n) begin
            req_state <= R_IDLE;
            cpl_state <= C_HDR;
        end else begin
            req_state <= req_next;
            cpl_state <= cpl_next;
        end
    end

    always_comb begin
        req_next   = req_state;
        read_chunk = 1'b0;
        case (req_state)
            R_IDLE: begin
                if (page_rdy && rem == 32'd0)
                    req_next = R_ADV;
                else if (page_rdy && free_ok)
                    req_next = R_REQ;
            end
            R_REQ: begin
                read_chunk = 1'b1;
                if (read_chunk_ack)
                    req_next = R_WAIT;
            end
            R_WAIT: begin
                if (rcv_cnt == req_qw && !err_hold)
                    req_next = R_ADV;
            end
            default: req_next = R_IDLE;
        endcase
    end

    always_comb begin
        cpl_next  = cpl_state;
        data_beat = 1'b0;
        case (cpl_state)
            C_HDR: begin
                if (beat && sof && hdr_cpld && hdr_sc && !eof)
                    cpl_next = C_H2;
            end
            C_H2: begin
                if (beat)
                    cpl_next = eof ? C_HDR : C_DATA;
            end
            default: begin
                if (beat) begin
                    data_beat = 1'b1;
                    if (eof)
                        cpl_next = C_HDR;
                end
            end
        endcase
    end

    always_ff @(posedge trn_clk) begin
        if (!reset_n) begin
            idx               <= '0;
            offset            <= '0;
            req_qw            <= '0;
            rcv_cnt           <= '0;
            read_chunk_addr   <= '0;
            read_chunk_qwords <= '0;
            huge_page_free    <= '0;
        end else begin
            huge_page_free <= '0;
            if (req_state == R_IDLE && req_next != R_IDLE) begin
                req_qw  <= chunk_qw;
                rcv_cnt <= '0;
                if (req_next == R_REQ) begin
                    read_chunk_addr   <= page_base + {29'd0, offset, 3'd0};
                    read_chunk_qwords <= chunk_qw;
                end
            end else if (data_beat && (req_state == R_REQ || req_state == R_WAIT)) begin
                rcv_cnt <= rcv_cnt + 10'd1;
            end
            if (req_state == R_ADV) begin
                if (page_done) begin
                    huge_page_free[idx] <= 1'b1;
                    offset <= '0;
                    idx    <= (idx == IDX_W'(NUM_PAGES - 1)) ? '0 : idx + IDX_W'(1);
                end else begin
                    offset <= new_off;
                end
            end
        end
    end

    // The reader address is only trusted once the synchronised change strobe says it is stable.
    always_ff @(posedge trn_clk) begin
        if (!reset_n) begin
            chg_s1    <= 1'b0;
            chg_s2    <= 1'b0;
            rd_addr_q <= '0;
            rd_ptr    <= '0;
            free_q    <= '0;
        end else begin
            chg_s1    <= commited_rd_address_change;
            chg_s2    <= chg_s1;
            rd_addr_q <= commited_rd_address;
            if (chg_s2)
                rd_ptr <= rd_addr_q;
            free_q <= rd_ptr - wr_addr - ONE;
        end
    end

    always_ff @(posedge trn_clk) begin
        if (!reset_n) begin
            wr_en   <= 1'b0;
            wr_data <= '0;
            wr_addr <= '0;
            upd_cnt <= '0;
        end else begin
            wr_en   <= data_beat && !ring_full;
            if (data_beat)
                wr_data <= trn_rd;
            wr_addr <= wr_next_addr;
            if (wr_en)
                upd_cnt <= UPD_W'(PULSE_CYCLES);
            else if (upd_cnt != '0)
                upd_cnt <= upd_cnt - UPD_W'(1);
        end
    end

endmodule
